// File: rtl/hazard_ctrl_v2.sv
// hazard_ctrl_v2: pipeline hazard controller for the IF/ID/EX/MA/WB pipeline.
// Combines EX operand forwarding, the load-use interlock, I/D-cache miss freeze
// and branch-redirect flush. It adds a stall FSM, a redirect held across
// D-miss freezes, a miss watchdog and saturating stall/redirect counters.
// Stall/flush outputs follow the state the controller is entering in the
// current cycle, so a transition cycle already shows the new behaviour.
module hazard_ctrl_v2 #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MISS_TO  = 255,
  parameter int CNT_W    = 16
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_IDEX_Need_Rs1,
  input  logic              i_IDEX_Need_Rs2,
  input  logic [REG_AW-1:0] i_IDEX_Rs1,
  input  logic [REG_AW-1:0] i_IDEX_Rs2,
  input  logic              i_EXMA_R_WE,
  input  logic              i_EXMA_Read_MEM,
  input  logic [REG_AW-1:0] i_EXMA_Rdst,
  input  logic              i_MAWB_R_WE,
  input  logic [REG_AW-1:0] i_MAWB_Rdst,
  input  logic              i_Redirect,
  input  logic              i_DCache_Miss,
  input  logic              i_ICache_Miss,
  input  logic              i_Cnt_Clr,
  output logic [1:0]        o_OP1_ExS,
  output logic [1:0]        o_OP2_ExS,
  output logic              o_PC_Stall,
  output logic              o_IFID_Stall,
  output logic              o_IDEX_Stall,
  output logic              o_EXMA_Stall,
  output logic              o_IFID_Flush,
  output logic              o_IDEX_Flush,
  output logic              o_EXMA_Flush,
  output logic              o_MAWB_Flush,
  output logic              o_Miss_Timeout,
  output logic [CNT_W-1:0]  o_Stall_Cnt,
  output logic [CNT_W-1:0]  o_Redirect_Cnt
);

  localparam int              WD_W    = $clog2(MISS_TO + 1);
  localparam logic [2:0]      LU_INIT = 3'(LOAD_LAT - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MISS_TO - 1);

  typedef enum logic [1:0] {ST_RUN, ST_LDUSE, ST_DMISS} state_t;

  state_t          state, state_nxt;
  logic [2:0]      lu_cnt, lu_cnt_nxt;
  logic            redir_pend;
  logic [WD_W-1:0] wd_cnt;
  logic            mode_dmiss, mode_ldu, accept_redir;
  logic            pc_stall;
  logic            fwd1_exma, fwd1_mawb, fwd2_exma, fwd2_mawb;
  logic            lu;

  assign fwd1_exma = i_IDEX_Need_Rs1 & i_EXMA_R_WE & ~i_EXMA_Read_MEM &
                     (i_EXMA_Rdst == i_IDEX_Rs1) & (i_IDEX_Rs1 != '0);
  assign fwd1_mawb = i_IDEX_Need_Rs1 & i_MAWB_R_WE &
                     (i_MAWB_Rdst == i_IDEX_Rs1) & (i_IDEX_Rs1 != '0);
  assign fwd2_exma = i_IDEX_Need_Rs2 & i_EXMA_R_WE & ~i_EXMA_Read_MEM &
                     (i_EXMA_Rdst == i_IDEX_Rs2) & (i_IDEX_Rs2 != '0);
  assign fwd2_mawb = i_IDEX_Need_Rs2 & i_MAWB_R_WE &
                     (i_MAWB_Rdst == i_IDEX_Rs2) & (i_IDEX_Rs2 != '0);

  assign lu = i_EXMA_Read_MEM & i_EXMA_R_WE & (i_EXMA_Rdst != '0) &
              ((i_IDEX_Need_Rs1 & (i_IDEX_Rs1 == i_EXMA_Rdst)) |
               (i_IDEX_Need_Rs2 & (i_IDEX_Rs2 == i_EXMA_Rdst)));

  // Decide this cycle's mode and next state: D-miss first, then an unfinished interlock, then redirect (live or replayed), then load-use.
  always_comb begin
    state_nxt    = ST_RUN;
    lu_cnt_nxt   = lu_cnt;
    mode_dmiss   = 1'b0;
    mode_ldu     = 1'b0;
    accept_redir = 1'b0;
    if (i_DCache_Miss) begin
      mode_dmiss = 1'b1;
      state_nxt  = ST_DMISS;
    end else if ((state == ST_LDUSE) && !i_Redirect && (lu_cnt != 3'd0)) begin
      mode_ldu   = 1'b1;
      state_nxt  = ST_LDUSE;
      lu_cnt_nxt = lu_cnt - 3'd1;
    end else if (i_Redirect || redir_pend) begin
      accept_redir = 1'b1;
      state_nxt    = ST_RUN;
    end else if (lu) begin
      mode_ldu   = 1'b1;
      state_nxt  = ST_LDUSE;
      lu_cnt_nxt = LU_INIT;
    end
  end

  assign pc_stall = mode_dmiss | mode_ldu | i_ICache_Miss;

  // Drive stall/flush pins and operand selects; everything is held idle while reset is asserted.
  always_comb begin
    o_OP1_ExS    = 2'b00;
    o_OP2_ExS    = 2'b00;
    o_PC_Stall   = 1'b0;
    o_IFID_Stall = 1'b0;
    o_IDEX_Stall = 1'b0;
    o_EXMA_Stall = 1'b0;
    o_IFID_Flush = 1'b0;
    o_IDEX_Flush = 1'b0;
    o_EXMA_Flush = 1'b0;
    o_MAWB_Flush = 1'b0;
    if (i_Rst_n) begin
      if (fwd1_exma)      o_OP1_ExS = 2'b01;
      else if (fwd1_mawb) o_OP1_ExS = 2'b10;
      if (fwd2_exma)      o_OP2_ExS = 2'b01;
      else if (fwd2_mawb) o_OP2_ExS = 2'b10;
      o_PC_Stall   = pc_stall;
      o_IFID_Stall = mode_dmiss | mode_ldu;
      o_IDEX_Stall = mode_dmiss | mode_ldu;
      o_EXMA_Stall = mode_dmiss;
      o_IFID_Flush = accept_redir | (~mode_dmiss & i_ICache_Miss);
      o_IDEX_Flush = accept_redir;
      o_EXMA_Flush = mode_ldu;
      o_MAWB_Flush = mode_dmiss;
    end
  end

  // Register FSM state, interlock count, pending redirect, watchdog and saturating counters.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state          <= ST_RUN;
      lu_cnt         <= 3'd0;
      redir_pend     <= 1'b0;
      wd_cnt         <= '0;
      o_Miss_Timeout <= 1'b0;
      o_Stall_Cnt    <= '0;
      o_Redirect_Cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
      if (mode_dmiss)        redir_pend <= redir_pend | i_Redirect;
      else if (accept_redir) redir_pend <= 1'b0;
      if (i_Cnt_Clr) begin
        wd_cnt         <= '0;
        o_Miss_Timeout <= 1'b0;
      end else if (mode_dmiss) begin
        if (wd_cnt == WD_LAST) o_Miss_Timeout <= 1'b1;
        else                   wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      if (i_Cnt_Clr)                             o_Stall_Cnt <= '0;
      else if (pc_stall && (o_Stall_Cnt != '1))  o_Stall_Cnt <= o_Stall_Cnt + 1'b1;
      if (i_Cnt_Clr)                                     o_Redirect_Cnt <= '0;
      else if (accept_redir && (o_Redirect_Cnt != '1))   o_Redirect_Cnt <= o_Redirect_Cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// tb_hazard_ctrl_v2: directed vectors for hazard_ctrl_v2 with LOAD_LAT=2, MISS_TO=8.
// Inputs change on the falling edge and outputs are sampled 1ns later.
module tb_hazard_ctrl_v2;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  logic              i_Clk, i_Rst_n;
  logic              need1, need2, exma_we, exma_ld, mawb_we;
  logic [REG_AW-1:0] rs1, rs2, exma_rdst, mawb_rdst;
  logic              redir, dmiss, imiss, clr;
  logic [1:0]        op1, op2;
  logic              pc_s, ifid_s, idex_s, exma_s, ifid_f, idex_f, exma_f, mawb_f;
  logic              timeout;
  logic [CNT_W-1:0]  stall_cnt, redir_cnt;
  logic [7:0]        ctl;
  int                check_cnt = 0;
  int                pass_cnt  = 0;

  assign ctl = {pc_s, ifid_s, idex_s, exma_s, ifid_f, idex_f, exma_f, mawb_f};

  hazard_ctrl_v2 #(.REG_AW(REG_AW), .LOAD_LAT(2), .MISS_TO(8), .CNT_W(CNT_W)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n),
    .i_IDEX_Need_Rs1(need1), .i_IDEX_Need_Rs2(need2),
    .i_IDEX_Rs1(rs1), .i_IDEX_Rs2(rs2),
    .i_EXMA_R_WE(exma_we), .i_EXMA_Read_MEM(exma_ld), .i_EXMA_Rdst(exma_rdst),
    .i_MAWB_R_WE(mawb_we), .i_MAWB_Rdst(mawb_rdst),
    .i_Redirect(redir), .i_DCache_Miss(dmiss), .i_ICache_Miss(imiss), .i_Cnt_Clr(clr),
    .o_OP1_ExS(op1), .o_OP2_ExS(op2),
    .o_PC_Stall(pc_s), .o_IFID_Stall(ifid_s), .o_IDEX_Stall(idex_s), .o_EXMA_Stall(exma_s),
    .o_IFID_Flush(ifid_f), .o_IDEX_Flush(idex_f), .o_EXMA_Flush(exma_f), .o_MAWB_Flush(mawb_f),
    .o_Miss_Timeout(timeout), .o_Stall_Cnt(stall_cnt), .o_Redirect_Cnt(redir_cnt)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Drive every pipeline-side input in one call.
  task automatic applyStimulus(input logic n1, input logic [REG_AW-1:0] r1,
                               input logic n2, input logic [REG_AW-1:0] r2,
                               input logic ewe, input logic eld, input logic [REG_AW-1:0] erd,
                               input logic mwe, input logic [REG_AW-1:0] mrd,
                               input logic rd, input logic dm, input logic im, input logic cl);
    need1 = n1; rs1 = r1; need2 = n2; rs2 = r2;
    exma_we = ewe; exma_ld = eld; exma_rdst = erd;
    mawb_we = mwe; mawb_rdst = mrd;
    redir = rd; dmiss = dm; imiss = im; clr = cl;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  // ctl bits: PC_S IFID_S IDEX_S EXMA_S | IFID_F IDEX_F EXMA_F MAWB_F
  initial begin
    i_Rst_n = 1'b0;
    applyStimulus(1, 3, 1, 3, 1, 0, 3, 1, 3, 1, 0, 1, 0);
    @(negedge i_Clk); #1;
    checkOutput("reset_ctl", ctl, 8'h00);
    checkOutput("reset_op1", op1, 2'b00);
    checkOutput("reset_op2", op2, 2'b00);
    checkOutput("reset_cnts", {stall_cnt, redir_cnt}, 32'h0);
    checkOutput("reset_timeout", timeout, 1'b0);

    // forwarding
    @(negedge i_Clk); i_Rst_n = 1'b1;
    applyStimulus(1, 3, 0, 3, 1, 0, 3, 1, 3, 0, 0, 0, 0); #1;
    checkOutput("fwd_op1_exma", op1, 2'b01);
    checkOutput("fwd_op2_noneed", op2, 2'b00);
    checkOutput("fwd_ctl_idle", ctl, 8'h00);
    @(negedge i_Clk);
    applyStimulus(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0); #1;
    checkOutput("fwd_r0_op1", op1, 2'b00);
    checkOutput("fwd_r0_op2", op2, 2'b00);
    @(negedge i_Clk);
    applyStimulus(1, 3, 1, 4, 1, 0, 4, 1, 3, 0, 0, 0, 0); #1;
    checkOutput("fwd_op1_mawb", op1, 2'b10);
    checkOutput("fwd_op2_exma", op2, 2'b01);

    // load-use, two bubbles
    @(negedge i_Clk);
    applyStimulus(0, 0, 1, 5, 1, 1, 5, 1, 5, 0, 0, 0, 0); #1;
    checkOutput("lu_c1_ctl", ctl, 8'hE2);
    checkOutput("lu_op2_skip_load", op2, 2'b10);
    @(negedge i_Clk);
    applyStimulus(0, 0, 1, 5, 1, 1, 5, 1, 5, 0, 0, 0, 0); #1;
    checkOutput("lu_c2_ctl", ctl, 8'hE2);
    @(negedge i_Clk); applyIdle(); #1;
    checkOutput("lu_done_ctl", ctl, 8'h00);
    checkOutput("lu_stall_cnt", stall_cnt, 2);

    // D-miss for 4 cycles, redirect in miss cycle 2
    for (int i = 1; i <= 4; i++) begin
      @(negedge i_Clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 2), 1, 0, 0); #1;
      checkOutput($sformatf("dmiss_c%0d_ctl", i), ctl, 8'hF1);
    end
    checkOutput("dmiss_redir_held", redir_cnt, 0);
    @(negedge i_Clk); applyIdle(); #1;
    checkOutput("dmiss_replay_ctl", ctl, 8'h0C);
    @(negedge i_Clk); applyIdle(); #1;
    checkOutput("dmiss_after_ctl", ctl, 8'h00);
    checkOutput("dmiss_redir_cnt", redir_cnt, 1);
    checkOutput("dmiss_stall_cnt", stall_cnt, 6);

    // watchdog: 10 miss cycles, two redirects merged into one
    for (int i = 1; i <= 10; i++) begin
      @(negedge i_Clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, (i == 2 || i == 5), 1, 0, 0); #1;
      if (i == 8) checkOutput("wd_c8_timeout", timeout, 1'b0);
      if (i == 9) checkOutput("wd_c9_timeout", timeout, 1'b1);
      if (i == 10) checkOutput("wd_c10_ctl", ctl, 8'hF1);
    end
    @(negedge i_Clk); applyIdle(); #1;
    checkOutput("wd_replay_ctl", ctl, 8'h0C);
    checkOutput("wd_sticky", timeout, 1'b1);
    @(negedge i_Clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    checkOutput("wd_merged_redir", redir_cnt, 2);
    checkOutput("wd_stall_cnt", stall_cnt, 16);
    checkOutput("wd_before_clr", timeout, 1'b1);
    @(negedge i_Clk); applyIdle(); #1;
    checkOutput("clr_timeout", timeout, 1'b0);
    checkOutput("clr_cnts", {stall_cnt, redir_cnt}, 32'h0);

    // load-use and redirect together: redirect wins
    @(negedge i_Clk);
    applyStimulus(1, 5, 0, 0, 1, 1, 5, 0, 0, 1, 0, 0, 0); #1;
    checkOutput("lu_redir_ctl", ctl, 8'h0C);
    @(negedge i_Clk); applyIdle(); #1;
    checkOutput("lu_redir_after", ctl, 8'h00);
    checkOutput("lu_redir_cnt", redir_cnt, 1);
    checkOutput("lu_redir_nostall", stall_cnt, 0);

    // I-miss alone
    @(negedge i_Clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
    checkOutput("imiss_ctl", ctl, 8'h88);
    @(negedge i_Clk); applyIdle(); #1;
    checkOutput("imiss_stall_cnt", stall_cnt, 1);

    // reset during D-miss with a pending redirect
    @(negedge i_Clk); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge i_Clk); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    @(negedge i_Clk); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    i_Rst_n = 1'b0; #1;
    checkOutput("rst_mid_ctl", ctl, 8'h00);
    checkOutput("rst_mid_cnts", {stall_cnt, redir_cnt}, 32'h0);
    @(negedge i_Clk); i_Rst_n = 1'b1; applyIdle(); #1;
    checkOutput("rst_release_ctl", ctl, 8'h00);
    @(negedge i_Clk); #1;
    checkOutput("rst_no_replay_ctl", ctl, 8'h00);
    checkOutput("rst_no_replay_cnt", redir_cnt, 0);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
